sram_arb_2p: RTL
================

Name: sram_arb_2p

Overview:
- Shares one single-port 1024x32 SRAM macro between two requester ports (p0, p1). Typical users: matrix loader and solver engine.
- After reset, zero-fills the whole array, then grants one access per cycle to the requesters using round-robin arbitration.
- Routes the 1-cycle-latency read data back to the port that issued the read.
- Sits directly in front of the SRAM macro and drives its CEN/WEN/A/D pins.

Parameters:
- BITS, 32, data word width.
- WORD_DEPTH, 1024, number of SRAM words.
- ADDR_WIDTH, 10, address width; WORD_DEPTH = 2**ADDR_WIDTH.
- INIT_EN, 1, 1 = zero-fill the array after reset; 0 = skip the fill.

Ports:
- CLK  in  1  single clock; all state changes on the rising edge.
- RST_N  in  1  synchronous, active-low reset.
- p0_req  in  1  port 0 access request; hold until granted.
- p0_we  in  1  port 0 access type: 1 = write, 0 = read.
- p0_addr  in  ADDR_WIDTH  port 0 word address.
- p0_wdata  in  BITS  port 0 write data.
- p0_gnt  out  1  port 0 request accepted this cycle (combinational).
- p0_rvalid  out  1  port 0 read data valid (registered).
- p0_rdata  out  BITS  port 0 read data.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1.
- init_done  out  1  high once the array is cleared and arbitration is live.
- sram_cen  out  1  SRAM chip enable, active low.
- sram_wen  out  1  SRAM write enable: 0 = write, 1 = read.
- sram_a  out  ADDR_WIDTH  SRAM address.
- sram_d  out  BITS  SRAM write data.
- sram_q  in  BITS  SRAM read data; valid one cycle after a read is enabled.

Behaviour:
- Reset (RST_N=0 sampled at a CLK edge):
  - state=INIT, clr_cnt=0, prio=p0, rvalid regs=0, rsel=0, init_done=0.
  - While RST_N=0, sram_cen=1 and both gnt=0 (combinational gating).
- States: INIT, RUN.
- INIT (INIT_EN=1):
  - Each cycle: sram_cen=0, sram_wen=0, sram_a=clr_cnt, sram_d=0; clr_cnt increments.
  - After the write with clr_cnt==WORD_DEPTH-1 -> RUN; init_done=1 from the next cycle.
  - Takes exactly WORD_DEPTH cycles.
  - Both gnt=0 during INIT; requests are ignored and must be held by the requesters.
- INIT with INIT_EN=0: goes directly to RUN on the first cycle after reset release.
- RUN arbitration (combinational in the same cycle):
  - Only one port requesting: that port is granted.
  - Both requesting: the port indicated by prio is granted.
  - No request: sram_cen=1 and sram_a/sram_d hold their previous values.
- RUN on a grant:
  - sram_cen=0; sram_wen=~we; sram_a/sram_d taken from the granted port's addr/wdata.
  - prio on the next cycle = the port that was not granted.
  - prio is unchanged if there was no grant.
  - Back-to-back grants are allowed every cycle; throughput is 1 access/cycle.
- Read response:
  - When a read is granted in cycle N, pX_rvalid=1 in cycle N+1 for that port only.
  - pX_rdata=sram_q is valid in that cycle; rdata is undefined when rvalid=0.
  - There is no response backpressure; the requester must accept rvalid immediately.
- Writes: completion is signalled by gnt only; no rvalid is generated.
- Ordering and hazards:
  - Accesses execute in grant order.
  - A read in cycle N+1 of an address written in cycle N returns the new data.
  - A write and read in the same cycle cannot occur (single grant).
- Reset mid-operation:
  - Aborts the INIT sweep or any pending rvalid (cleared at the reset edge).
  - Re-runs the full INIT sweep from address 0.
- Reset mid-operation memory contents: entries already written are not preserved; after INIT the array is all zero.

Test Plan:
- Release reset with INIT_EN=1 -> sram_cen=0, sram_wen=0 for exactly 1024 cycles with sram_a 0..1023 and sram_d=0; init_done rises the cycle after the a=1023 write; p0_gnt=0 throughout despite p0_req=1.
- After init, p0 writes 0xDEADBEEF to addr 5 -> p0_gnt=1 same cycle; next cycle p0 reads addr 5 -> p0_rvalid=1 one cycle later with p0_rdata=0xDEADBEEF, p1_rvalid=0. A read of any untouched addr (e.g. 700) returns 0.
- Both ports hold req=1 for 6 cycles, reading addrs 1 and 2 -> grant order p0,p1,p0,p1,p0,p1; each rvalid pulses only on the matching port with the correct data.
- p1 alone requests reads for 4 consecutive cycles -> p1_gnt=1 all 4 cycles; then both request -> p0 granted first (prio was p0).
- p0 writes 0x12345678 to addr 9 in cycle N, p1 reads addr 9 in cycle N+1 -> p1_rdata=0x12345678 in cycle N+2.
- Assert RST_N=0 at clr_cnt=300 with a read outstanding -> rvalid=0 and sram_cen=1 during reset; after release the sweep restarts at a=0 and lasts the full 1024 cycles.

Source files
------------

// File: rtl/sram_arb_2p.sv
// Two-port round-robin arbiter in front of a single-port SRAM macro.
// Zero-fills the array after reset, then grants one access per cycle and steers read data back.
module sram_arb_2p #(
  parameter int BITS       = 32,
  parameter int WORD_DEPTH = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [BITS-1:0]       p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [BITS-1:0]       p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [BITS-1:0]       p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [BITS-1:0]       p1_rdata,
  output logic                  init_done,
  output logic                  sram_cen,
  output logic                  sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [BITS-1:0]       sram_d,
  input  logic [BITS-1:0]       sram_q
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_q, clr_d;
  logic                  prio_q, prio_d;   // 0: p0 wins a tie, 1: p1 wins
  logic                  rv_q, rv_d;
  logic                  rsel_q, rsel_d;   // port that owns the in-flight read
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] a_q, a_d;
  logic [BITS-1:0]       d_q, d_d;

  logic                  gnt0, gnt1, cen, wen;
  logic [ADDR_WIDTH-1:0] a;
  logic [BITS-1:0]       d;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_INIT;
      clr_q   <= '0;
      prio_q  <= 1'b0;
      rv_q    <= 1'b0;
      rsel_q  <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      prio_q  <= prio_d;
      rv_q    <= rv_d;
      rsel_q  <= rsel_d;
      done_q  <= done_d;
      a_q     <= a_d;
      d_q     <= d_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    prio_d  = prio_q;
    rv_d    = 1'b0;
    rsel_d  = rsel_q;
    done_d  = done_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    cen     = 1'b1;
    wen     = 1'b1;
    a       = a_q;
    d       = d_q;
    case (state_q)
      S_INIT: begin
        if (INIT_EN) begin
          cen   = 1'b0;
          wen   = 1'b0;
          a     = clr_q;
          d     = '0;
          clr_d = clr_q + 1'b1;
          if (clr_q == ADDR_WIDTH'(WORD_DEPTH - 1)) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end
        end else begin
          state_d = S_RUN;
          done_d  = 1'b1;
        end
      end
      S_RUN: begin
        gnt0 = p0_req & (~p1_req | ~prio_q);
        gnt1 = p1_req & (~p0_req |  prio_q);
        if (gnt0) begin
          cen    = 1'b0;
          wen    = ~p0_we;
          a      = p0_addr;
          d      = p0_wdata;
          prio_d = 1'b1;
          rv_d   = ~p0_we;
          rsel_d = 1'b0;
        end else if (gnt1) begin
          cen    = 1'b0;
          wen    = ~p1_we;
          a      = p1_addr;
          d      = p1_wdata;
          prio_d = 1'b0;
          rv_d   = ~p1_we;
          rsel_d = 1'b1;
        end
      end
      default: state_d = S_INIT;
    endcase
    // Idle cycles keep the last address/data on the macro pins.
    a_d = a;
    d_d = d;
  end

  assign p0_gnt    = gnt0 & RST_N;
  assign p1_gnt    = gnt1 & RST_N;
  assign sram_cen  = cen | ~RST_N;
  assign sram_wen  = wen;
  assign sram_a    = a;
  assign sram_d    = d;
  assign p0_rvalid = rv_q & ~rsel_q;
  assign p1_rvalid = rv_q &  rsel_q;
  assign p0_rdata  = sram_q;
  assign p1_rdata  = sram_q;
  assign init_done = done_q;

endmodule
